// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants for the async FIFO read side.
// Default word width and output-buffer occupancy codes.
package fifo_pkg;

  localparam int DATA_W_DEF = 8;

  typedef logic [1:0] occ_t;

  localparam occ_t OCC_S0 = 2'd0;
  localparam occ_t OCC_S1 = 2'd1;
  localparam occ_t OCC_S2 = 2'd2;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: valid/ready word stream leaving the
// FIFO read side toward the data processor.
interface fifo_rd_stream_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  modport master (
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    output m_ready
  );

endinterface

// File: rtl/fifo_out_buf2.sv
// fifo_out_buf2: 2-entry ring storage, write at tail, read at
// head; head entry is presented registered on rd_data.
module fifo_out_buf2
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              head_q;
  logic              head_d;
  logic              tail_q;
  logic              tail_d;

  // Advance tail on write, head on read.
  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    if (wr_en) begin
      mem_d[tail_q] = wr_data;
      tail_d        = ~tail_q;
    end
    if (rd_en) begin
      head_d = ~head_q;
    end
  end

  // Storage and pointer registers; cleared so m_data reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      head_q   <= head_d;
      tail_q   <= tail_d;
    end
  end

  assign rd_data = mem_q[head_q];

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: FIFO read port to valid/ready stream bridge.
// Optional pop statistics under `FIFO_RD_STATS_EN.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              empty,
  output logic              rd_enable_fifo,
  input  logic [DATA_W-1:0] rd_data,
  fifo_rd_stream_if.master  m
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [CNT_W-1:0]  pop_count
`endif
);

  occ_t       occ_q;
  occ_t       occ_d;
  logic       inflight_q;
  logic       inflight_d;
  logic       xfer;
  logic [2:0] avail;

  // Occupancy state register and in-flight flag.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      occ_q      <= OCC_S0;
      inflight_q <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
    end
  end

  // Next occupancy: +1 on capture, -1 on transfer.
  always_comb begin
    occ_d = occ_q;
    case (occ_q)
      OCC_S0: begin
        if (inflight_q) occ_d = OCC_S1;
      end
      OCC_S1: begin
        if (inflight_q && !xfer) occ_d = OCC_S2;
        else if (!inflight_q && xfer) occ_d = OCC_S0;
      end
      OCC_S2: begin
        if (!inflight_q && xfer) occ_d = OCC_S1;
      end
      default: occ_d = OCC_S0;
    endcase
  end

  // Credit-based pop request, gated off while in reset.
  always_comb begin
    m.m_valid      = (occ_q != OCC_S0);
    xfer           = m.m_valid & m.m_ready;
    avail          = 3'(occ_q) + 3'(inflight_q) - 3'(xfer);
    rd_enable_fifo = rrst_n & ~empty & (avail < 3'd2);
    inflight_d     = rd_enable_fifo;
  end

  fifo_out_buf2 #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk     (rclk),
    .rst_n   (rrst_n),
    .wr_en   (inflight_q),
    .wr_data (rd_data),
    .rd_en   (xfer),
    .rd_data (m.m_data)
  );

`ifdef FIFO_RD_STATS_EN
  logic [CNT_W-1:0] pop_count_q;
  logic [CNT_W-1:0] pop_count_d;

  // Count accepted pops; wraps naturally.
  always_comb begin
    pop_count_d = pop_count_q;
    if (rd_enable_fifo) pop_count_d = pop_count_q + CNT_W'(1);
  end

  // Pop counter register.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) pop_count_q <= '0;
    else         pop_count_q <= pop_count_d;
  end

  assign pop_count = pop_count_q;
`else
  // Counter width only matters with statistics enabled.
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: FIFO model feeding the DUT, scoreboard
// on the output stream, directed latency/credit checks.
module tb_fifo_rd_stream;

  localparam int DW = 8;
  localparam int CW = 8;

  logic          rclk = 1'b0;
  logic          rrst_n = 1'b0;
  logic          empty;
  logic          rd_enable_fifo;
  logic [DW-1:0] rd_data = '0;
`ifdef FIFO_RD_STATS_EN
  logic [CW-1:0] pop_count;
`endif

  fifo_rd_stream_if #(.DATA_W(DW)) s ();

  fifo_rd_stream #(
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .rclk           (rclk),
    .rrst_n         (rrst_n),
    .empty          (empty),
    .rd_enable_fifo (rd_enable_fifo),
    .rd_data        (rd_data),
    .m              (s.master)
`ifdef FIFO_RD_STATS_EN
    ,
    .pop_count      (pop_count)
`endif
  );

  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // FIFO model: registered read data, pointer compare empty.
  logic [DW-1:0] fmem [1024];
  int            wptr = 0;
  int            rptr = 0;
  int            pop_n = 0;
  logic          fifo_flush = 1'b0;
  logic [7:0]    sb [$];

  assign empty = (wptr == rptr);

  always @(posedge rclk) begin
    if (fifo_flush) begin
      rptr <= wptr;
    end else if (rd_enable_fifo && !empty) begin
      rd_data <= fmem[rptr % 1024];
      rptr    <= rptr + 1;
      pop_n   <= pop_n + 1;
    end
  end

  task automatic push(input logic [7:0] w);
    fmem[wptr % 1024] = w;
    sb.push_back(w);
    wptr++;
  endtask

  // Scoreboard: every transfer must match the oldest pushed word.
  always @(negedge rclk) begin
    if (rrst_n && s.m_valid && s.m_ready) begin
      logic [31:0] exp;
      exp = (sb.size() != 0) ? 32'(sb.pop_front()) : 32'hDEAD_BEEF;
      chk("data", 32'(s.m_data), exp);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge rclk);
    #1;
  endtask

  task automatic drain(input string tag, input int max);
    int n;
    n = 0;
    while ((sb.size() != 0 || s.m_valid || !empty) && n < max) begin
      cyc(1);
      n++;
    end
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  int p0;
  int vcnt;

  initial begin
    s.m_ready = 1'b0;
    rrst_n    = 1'b0;

    // 1: reset holds pop off even with data waiting
    cyc(2);
    push(8'h5A);
    @(negedge rclk);
    chk("rst_rden", 32'(rd_enable_fifo), 32'd0);
    chk("rst_valid", 32'(s.m_valid), 32'd0);
    chk("rst_data", 32'(s.m_data), 32'd0);
    @(posedge rclk);
    #1;
    rrst_n    = 1'b1;
    s.m_ready = 1'b1;
    @(negedge rclk);
    chk("rel_pop", 32'(rd_enable_fifo), 32'd1);
    drain("t1_drain", 50);

    // 2: streaming 0x01..0x10
    p0 = pop_n;
    for (int i = 1; i <= 16; i++) push(8'(i));
    for (int i = 0; i < 16; i++) begin
      @(negedge rclk);
      chk("t2_pop", 32'(rd_enable_fifo && !empty), 32'd1);
      if (i >= 2) chk("t2_valid", 32'(s.m_valid), 32'd1);
    end
    @(negedge rclk);
    chk("t2_valid", 32'(s.m_valid), 32'd1);
    @(negedge rclk);
    chk("t2_valid", 32'(s.m_valid), 32'd1);
    @(negedge rclk);
    chk("t2_idle", 32'(s.m_valid), 32'd0);
    chk("t2_pops", 32'(pop_n - p0), 32'd16);
    drain("t2_drain", 50);

    // 3: backpressure stops after two pops
    cyc(1);
    s.m_ready = 1'b0;
    p0 = pop_n;
    for (int i = 0; i < 4; i++) push(8'h30 + 8'(i));
    cyc(6);
    @(negedge rclk);
    chk("t3_pops", 32'(pop_n - p0), 32'd2);
    chk("t3_rden", 32'(rd_enable_fifo), 32'd0);
    chk("t3_valid", 32'(s.m_valid), 32'd1);
    chk("t3_hold", 32'(s.m_data), 32'h30);
    @(posedge rclk);
    #1;
    s.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge rclk);
      chk("t3_gapless", 32'(s.m_valid), 32'd1);
    end
    drain("t3_drain", 50);

    // 4: single last word
    cyc(1);
    p0 = pop_n;
    push(8'hA5);
    vcnt = 0;
    repeat (6) begin
      @(negedge rclk);
      vcnt += int'(s.m_valid);
    end
    chk("t4_vcycles", 32'(vcnt), 32'd1);
    chk("t4_pops", 32'(pop_n - p0), 32'd1);
    chk("t4_rden", 32'(rd_enable_fifo), 32'd0);

    // 5: reset with buffered and in-flight words
    cyc(1);
    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
    cyc(3);
    rrst_n     = 1'b0;
    fifo_flush = 1'b1;
    sb.delete();
    @(negedge rclk);
    chk("t5_rden", 32'(rd_enable_fifo), 32'd0);
    chk("t5_valid", 32'(s.m_valid), 32'd0);
    chk("t5_data", 32'(s.m_data), 32'd0);
    @(posedge rclk);
    #1;
    fifo_flush = 1'b0;
    rrst_n     = 1'b1;
    p0 = pop_n;
    vcnt = 0;
    repeat (6) begin
      @(negedge rclk);
      vcnt += int'(s.m_valid);
    end
    chk("t5_after", 32'(vcnt), 32'd0);
    chk("t5_pops", 32'(pop_n - p0), 32'd0);

    // 6: 300 words under random backpressure
    cyc(1);
    rrst_n = 1'b0;
    cyc(1);
    rrst_n = 1'b1;
    p0 = pop_n;
    for (int i = 0; i < 300; i++) push(8'($urandom));
    for (int n = 0; n < 3000; n++) begin
      if (sb.size() == 0 && empty && !s.m_valid) break;
      s.m_ready = 1'($urandom_range(0, 1));
      cyc(1);
    end
    s.m_ready = 1'b1;
    chk("t6_drain", 32'(sb.size()), 32'd0);
    chk("t6_pops", 32'(pop_n - p0), 32'd300);
`ifdef FIFO_RD_STATS_EN
    chk("t6_count", 32'(pop_count), 32'd44);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
